// File: rtl/mem_bus_if.sv
// mem_bus_if: host request/response handshake plus memory strobes and address of mem_bus_master.
// The shared DataBus is a tristate net, so it stays a plain inout port on the master.
interface mem_bus_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              MemWrite;
  logic              MemRead;
  logic [ADDR_W-1:0] Addr;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, MemWrite, MemRead, Addr
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, MemWrite, MemRead, Addr
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding host-to-memory master with registered strobes and a tristate DataBus.
// Define MEM_BUS_MASTER_VERIFY_EN to read back every write and flag a mismatch on rsp_err.
module mem_bus_master #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 6,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_if.master         bus,
  inout  wire  [DATA_W-1:0] DataBus
);
  typedef enum logic [2:0] {IDLE, WR, WR_TURN, RD, RD_TURN, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  // RD spends its first cycle as address setup (counter loaded, MemRead still low), then READ_WAIT strobe cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (bus.req_valid && ready_q) begin
        state_d = bus.req_write ? WR : RD;
        wr_d    = bus.req_write;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        cnt_d   = 4'(READ_WAIT);
      end
      WR: state_d = WR_TURN;
`ifdef MEM_BUS_MASTER_VERIFY_EN
      WR_TURN: begin
        state_d = RD;
        cnt_d   = 4'(READ_WAIT);
      end
`else
      WR_TURN: state_d = DONE;
`endif
      RD: begin
        state_d = cnt_q == 4'd0 ? RD_TURN : RD;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        rd_d    = cnt_q == 4'd0 ? DataBus : rd_q;
      end
      RD_TURN: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_wr_d    = state_d == WR;
    mem_rd_d    = state_q == RD && cnt_q != 4'd0;
    ready_d     = state_d == IDLE;
    rsp_valid_d = state_d == DONE;
`ifdef MEM_BUS_MASTER_VERIFY_EN
    rsp_rdata_d = rsp_valid_d ? rd_q : rsp_rdata_q;
    rsp_err_d   = rsp_valid_d ? wr_q && rd_q != wdata_q : rsp_err_q;
`else
    rsp_rdata_d = rsp_valid_d ? (wr_q ? '0 : rd_q) : rsp_rdata_q;
    rsp_err_d   = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.MemWrite  = mem_wr_q;
  assign bus.MemRead   = mem_rd_q;
  assign bus.Addr      = addr_q;
  // The bus driver shares the MemWrite flop, so it is enabled exactly in WR and drops with reset.
  assign DataBus = mem_wr_q ? wdata_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: randomized transactions against a transaction-level memory/latency model.
// A weak "keeper" pattern on DataBus reveals whether the master has released the bus.
module tb_mem_bus_master;
  localparam int RW = 3;
  localparam logic [63:0] KEEP = 64'hA5A5_5A5A_C3C3_3C3C;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mem_clr = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] mem [64];
  logic [63:0] ref_mem [64];
  logic [63:0] last_rdata = '0;
  wire [63:0] data_bus;
  mem_bus_if #(.DATA_W(64), .ADDR_W(6)) ifc ();
  mem_bus_master #(.DATA_W(64), .ADDR_W(6), .READ_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.master), .DataBus(data_bus)
  );
  always #5 clk = ~clk;
  assign data_bus = ifc.MemWrite ? {64{1'bz}} : (ifc.MemRead ? mem[ifc.Addr] : KEEP);
  always @(posedge clk)
    if (mem_clr) for (int i = 0; i < 64; i++) mem[i] <= {~32'(i), 32'(i) * 32'h0101_0101};
    else if (ifc.MemWrite) mem[ifc.Addr] <= (ifc.Addr == 6'h0A && data_bus == 64'd1) ? data_bus ^ 64'd1 : data_bus;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    check("strobe_overlap", 64'(ifc.MemWrite & ifc.MemRead), 64'd0);
    if (!ifc.MemWrite && !ifc.MemRead) check("bus_release", data_bus, KEEP);
    else if (ifc.MemRead) check("bus_read", data_bus, mem[ifc.Addr]);
  end
  task automatic run_txn(input bit w, input logic [5:0] a, input logic [63:0] d, input bit hold, input int gap);
    logic [63:0] stored, exp_rd;
    bit exp_err;
    int exp_lat, exp_nrd, waits, lat, n_wr, n_rd;
    if (w) begin
      stored = (a == 6'h0A && d == 64'd1) ? d ^ 64'd1 : d;
      ref_mem[a] = stored;
`ifdef MEM_BUS_MASTER_VERIFY_EN
      exp_rd = stored; exp_err = stored != d; exp_lat = RW + 5; exp_nrd = RW;
`else
      exp_rd = '0; exp_err = 1'b0; exp_lat = 3; exp_nrd = 0;
`endif
    end else begin
      exp_rd = ref_mem[a]; exp_err = 1'b0; exp_lat = RW + 3; exp_nrd = RW;
    end
    ifc.req_valid = 1'b1; ifc.req_write = w; ifc.req_addr = a; ifc.req_wdata = d;
    waits = 0;
    while (!ifc.req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
      check("rsp_pulse", 64'(ifc.rsp_valid), 64'd0);
    end
    if (gap >= 0) check("reaccept_gap", 64'(waits), 64'(gap));
    if (!ifc.req_ready) begin
      check("ready_timeout", 64'(ifc.req_ready), 64'd1);
      return;
    end
    n_wr = 0; n_rd = 0; lat = 0;
    for (int t = 1; t <= 40 && lat == 0; t++) begin
      @(negedge clk);
      if (t == 1 && !hold) ifc.req_valid = 1'b0;
      check("busy_ready", 64'(ifc.req_ready), 64'd0);
      check("addr_hold", 64'(ifc.Addr), 64'(a));
      if (ifc.MemWrite) begin
        n_wr++;
        check("wr_data", data_bus, d);
      end
      if (ifc.MemRead) n_rd++;
      if (ifc.rsp_valid) lat = t;
      else check("rdata_hold", ifc.rsp_rdata, last_rdata);
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_rdata", ifc.rsp_rdata, exp_rd);
    check("rsp_err", 64'(ifc.rsp_err), 64'(exp_err));
    check("n_memwrite", 64'(n_wr), 64'(w));
    check("n_memread", 64'(n_rd), 64'(exp_nrd));
    last_rdata = exp_rd;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit w;
    logic [5:0] a;
    logic [63:0] d;
    for (int i = 0; i < 64; i++) ref_mem[i] = {~32'(i), 32'(i) * 32'h0101_0101};
    ifc.req_valid = 1'b0; ifc.req_write = 1'b1; ifc.req_addr = 6'h05; ifc.req_wdata = '1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_memwrite", 64'(ifc.MemWrite), 64'd0);
    check("rst_memread", 64'(ifc.MemRead), 64'd0);
    check("rst_ready", 64'(ifc.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(ifc.rsp_err), 64'd0);
    check("rst_rdata", ifc.rsp_rdata, 64'd0);
    check("rst_addr", 64'(ifc.Addr), 64'd0);
    check("rst_bus", data_bus, KEEP);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifc.req_valid = ~ifc.req_valid;
      check("rst_hold_ready", 64'(ifc.req_ready), 64'd0);
      check("rst_hold_memwrite", 64'(ifc.MemWrite), 64'd0);
      check("rst_hold_memread", 64'(ifc.MemRead), 64'd0);
    end
    mem_clr = 1'b0;
    ifc.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(ifc.req_ready), 64'd1);
    run_txn(1'b1, 6'h05, 64'hDEADBEEF_CAFEF00D, 1'b0, -1);
    run_txn(1'b0, 6'h05, 64'd0, 1'b0, 1);
    run_txn(1'b1, 6'h3F, 64'h0123_4567_89AB_CDEF, 1'b1, -1);
    run_txn(1'b0, 6'h3F, 64'd0, 1'b0, 1);
    run_txn(1'b1, 6'h0A, 64'd1, 1'b0, 1);
    run_txn(1'b0, 6'h0A, 64'd0, 1'b0, 1);
    run_txn(1'b0, 6'h00, 64'd0, 1'b0, 1);
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_addr = 6'h11; ifc.req_wdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    check("wr_before_abort", 64'(ifc.MemWrite), 64'd1);
    ifc.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_memwrite", 64'(ifc.MemWrite), 64'd0);
    check("abort_memread", 64'(ifc.MemRead), 64'd0);
    check("abort_bus", data_bus, KEEP);
    check("abort_ready", 64'(ifc.req_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(ifc.rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    last_rdata = '0;
    @(negedge clk);
    check("abort_ready_after", 64'(ifc.req_ready), 64'd1);
    check("abort_no_rsp_after", 64'(ifc.rsp_valid), 64'd0);
    run_txn(1'b0, 6'h11, 64'd0, 1'b0, -1);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = 6'h3F;
        1: a = 6'h0A;
        default: a = 6'($urandom);
      endcase
      d = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
      run_txn(w, a, d, 1'b0, 1);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter DATA_W, default 64: width of the shared memory data bus and the host data.
REQ-002 Parameter ADDR_W, default 6: memory address width (64 locations).
REQ-003 Parameter READ_WAIT, default 1, legal range 1-15: number of cycles MemRead is held before DataBus is sampled.
REQ-004 Clock and reset are fixed as follows: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-005 clk  input  1  clock; all state updates occur on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  host request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_write  input  1  1=write, 0=read.
REQ-010 req_addr  input  ADDR_W  target memory location.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  DATA_W  read data, or verify readback data.
REQ-014 rsp_err  output  1  write-verify mismatch flag.
REQ-015 MemWrite  output  1  memory write strobe.
REQ-016 MemRead  output  1  memory read strobe.
REQ-017 Addr  output  ADDR_W  memory address.
REQ-018 DataBus  inout  DATA_W  shared tristate data bus.

Function
REQ-019 The FSM SHALL have the states IDLE, WR, WR_TURN, RD, RD_TURN and DONE, with IDLE as the reset state.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 When req_valid and req_ready are both 1 at a clock edge, the block SHALL register req_write, req_addr and req_wdata. The next state SHALL be WR if req_write=1, otherwise RD.
REQ-022 In WR, for exactly one cycle, the block SHALL drive MemWrite=1, MemRead=0, Addr=the registered address and DataBus=the registered data.
REQ-023 WR_TURN SHALL last one cycle with MemWrite=0, MemRead=0 and DataBus released to Z. The next state SHALL be DONE, or RD when the feature in REQ-033 is enabled.
REQ-024 In RD, the block SHALL hold MemRead=1 and Addr for READ_WAIT cycles, counted by a 4-bit down-counter, and SHALL NOT drive DataBus. DataBus SHALL be sampled into the read register at the edge ending the last RD cycle.
REQ-025 RD_TURN SHALL last one cycle with MemRead=0 and the bus released. The next state SHALL be DONE.
REQ-026 In DONE, for one cycle, the block SHALL drive rsp_valid=1 with rsp_rdata and rsp_err valid, then return to IDLE. There is no response backpressure.
REQ-027 Timing from the accept edge at cycle k:
- write without verify: rsp_valid in cycle k+3;
- read: rsp_valid in cycle k+READ_WAIT+3;
- next acceptance: no earlier than the cycle after DONE.
REQ-028 MemWrite and MemRead SHALL never both be 1. The DataBus driver SHALL be enabled only in WR.
REQ-029 Outside RD and WR, Addr SHALL hold its last value. rsp_rdata SHALL hold its value until the next DONE.
REQ-030 Address 2^ADDR_W-1 (0x3F) SHALL be handled like any other address, with no wrap or auto-increment.

Reset
REQ-031 While rst_n=0, independent of clk, the block SHALL force:
- MemWrite=0, MemRead=0, DataBus=Z;
- rsp_valid=0, rsp_err=0, rsp_rdata=0, Addr=0;
- req_ready=0;
- state=IDLE and the wait counter=0.
REQ-032 Reset asserted mid-operation SHALL abort the transaction with no response. req_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-033 With MEM_BUS_MASTER_VERIFY_EN defined, every write SHALL be followed by an RD/RD_TURN readback of the same address before DONE, with:
- rsp_rdata = the readback value;
- rsp_err = 1 if the readback differs from the written data;
- write rsp_valid in cycle k+READ_WAIT+5.
REQ-034 With MEM_BUS_MASTER_VERIFY_EN undefined:
- writes SHALL go WR_TURN→DONE;
- rsp_err SHALL be constant 0;
- rsp_rdata SHALL be 0 on write responses.

Verification
REQ-035 Reset: hold rst_n=0 and toggle req_valid -> MemWrite=0, MemRead=0, DataBus=Z, req_ready=0. After release -> req_ready=1 the next cycle.
REQ-036 Write addr 0x05, data 0xDEADBEEF_CAFEF00D -> exactly one cycle with MemWrite=1, Addr=0x05 and that value on DataBus. rsp_valid=1 at k+3, rsp_err=0 (macro off).
REQ-037 Read addr 0x05 with READ_WAIT=3 -> MemRead=1 for 3 cycles. rsp_valid at k+6 with rsp_rdata=0xDEADBEEF_CAFEF00D.
REQ-038 req_valid held high for a write to 0x3F then a read of 0x3F -> second accept only after DONE. MemWrite and MemRead never overlap. The bus is Z in the turnaround cycles. Read returns the written data.
REQ-039 Macro on, memory model flips bit 0 on write of 0x1 to addr 0x0A -> rsp_valid at k+READ_WAIT+5 with rsp_err=1 and rsp_rdata=0x0.
REQ-040 Assert rst_n=0 during the WR cycle -> MemWrite and DataBus release asynchronously within the same cycle. No rsp_valid is produced. The block is in IDLE after release.
